// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every handshake and bus signal around the shared memory port: the
// instruction-fetch requester, the load/store requester and the memory macro.
//
//   slave  : the arbiter's view (takes requests and read data, drives grants,
//            read strobes and memory commands)
//   master : the environment's view (requesters plus the memory macro)
//
// Signals
//   if_req / if_addr                     fetch request, held until if_gnt
//   if_gnt / if_rvalid / if_rdata        fetch grant pulse and read return
//   d_req / d_we / d_addr / d_wdata      data request, held until d_gnt
//   d_gnt / d_rvalid / d_rdata           data grant pulse and load return
//   mem_rd / mem_we / mem_addr / mem_wdata   memory command
//   mem_rdata                            memory read data (fixed latency)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_rd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters and memory macro side.
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_rd, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    // Arbiter side.
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_rd, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single memory port between instruction fetch (IF) and the
// load/store data path (D) of the multi-cycle core. One transaction is in
// flight at a time. A read is issued in IDLE, the arbiter waits MEM_LAT
// cycles in WAIT, and then returns mem_rdata to the owner with a one-cycle
// rvalid strobe. A store completes in its grant cycle. Round-robin via
// `last` breaks ties.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  cycles from mem_rd to valid mem_rdata, legal range 1..15
//
// Ports
//   clk      clock
//   reset    asynchronous, active-high reset
//   bus_io   mem_port_arbiter_if.slave: requester handshakes and memory bus
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input logic                 clk,
    input logic                 reset,
    mem_port_arbiter_if.slave   bus_io
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    // WAIT counts down from here to 0, and rvalid fires on the 0 cycle. That
    // puts rvalid MEM_LAT cycles after the mem_rd cycle.
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        owner_q, owner_d;
    logic        last_q,  last_d;

    logic              ifWin;
    logic              dWin;

    logic              ifGnt_o;
    logic              ifRvalid_o;
    logic [DATA_W-1:0] ifRdata_o;
    logic              dGnt_o;
    logic              dRvalid_o;
    logic [DATA_W-1:0] dRdata_o;
    logic              memRd_o;
    logic              memWe_o;
    logic [ADDR_W-1:0] memAddr_o;
    logic [DATA_W-1:0] memWdata_o;

    // State register. Reset sets `last` to D, so IF wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            owner_q <= OWNER_IF;
            last_q  <= OWNER_D;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Next-state and output logic. Grants and memory commands are
    // combinational from the requests in IDLE, so a request issues in the
    // cycle it first appears. While reset is asserted, every output is held
    // at 0, even if a requester is already asserting its request.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_d     = last_q;

        ifWin      = 1'b0;
        dWin       = 1'b0;

        ifGnt_o    = 1'b0;
        ifRvalid_o = 1'b0;
        ifRdata_o  = '0;
        dGnt_o     = 1'b0;
        dRvalid_o  = 1'b0;
        dRdata_o   = '0;
        memRd_o    = 1'b0;
        memWe_o    = 1'b0;
        memAddr_o  = '0;
        memWdata_o = '0;

        if (!reset) begin
            case (state_q)
                IDLE: begin
                    // IF wins when alone or when D took the previous grant.
                    ifWin = bus_io.if_req && (!bus_io.d_req || (last_q == OWNER_D));
                    dWin  = bus_io.d_req && !ifWin;

                    if (ifWin) begin
                        ifGnt_o   = 1'b1;
                        memRd_o   = 1'b1;
                        memAddr_o = bus_io.if_addr;
                        last_d    = OWNER_IF;
                        owner_d   = OWNER_IF;
                        cnt_d     = CNT_LOAD;
                        state_d   = WAIT;
                    end else if (dWin) begin
                        dGnt_o    = 1'b1;
                        memAddr_o = bus_io.d_addr;
                        last_d    = OWNER_D;
                        if (bus_io.d_we) begin
                            // A store finishes in its grant cycle and has
                            // no return phase, so the port stays in IDLE.
                            memWe_o    = 1'b1;
                            memWdata_o = bus_io.d_wdata;
                        end else begin
                            memRd_o = 1'b1;
                            owner_d = OWNER_D;
                            cnt_d   = CNT_LOAD;
                            state_d = WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        if (owner_q == OWNER_IF) begin
                            ifRvalid_o = 1'b1;
                            ifRdata_o  = bus_io.mem_rdata;
                        end else begin
                            dRvalid_o = 1'b1;
                            dRdata_o  = bus_io.mem_rdata;
                        end
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus_io.if_gnt    = ifGnt_o;
    assign bus_io.if_rvalid = ifRvalid_o;
    assign bus_io.if_rdata  = ifRdata_o;
    assign bus_io.d_gnt     = dGnt_o;
    assign bus_io.d_rvalid  = dRvalid_o;
    assign bus_io.d_rdata   = dRdata_o;
    assign bus_io.mem_rd    = memRd_o;
    assign bus_io.mem_we    = memWe_o;
    assign bus_io.mem_addr  = memAddr_o;
    assign bus_io.mem_wdata = memWdata_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A MEM_LAT=2 instance is driven from a
// per-cycle vector table. A MEM_LAT=1 instance is exercised by a short
// hand-written sequence. Each instance has a simple memory model that
// returns memModel(addr) for the last address that was read.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int checksRun    = 0;
    int checksPassed = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus  ();
    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1)) dutLat1 (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus1)
    );

    always #5 clk = ~clk;

    // The memory model's data is a fixed function of the address, so the
    // bench can compute the expected value independently.
    function automatic logic [63:0] memModel(input logic [31:0] a);
        return {a ^ 32'hC0DE_0000, ~a};
    endfunction

    logic [31:0] rdAddr0 = '0;
    logic [31:0] rdAddr1 = '0;

    always @(posedge clk) begin
        if (bus.mem_rd)  rdAddr0 <= bus.mem_addr;
        if (bus1.mem_rd) rdAddr1 <= bus1.mem_addr;
    end

    assign bus.mem_rdata  = memModel(rdAddr0);
    assign bus1.mem_rdata = memModel(rdAddr1);

    // One record describes one clock cycle: the inputs for that cycle and
    // the outputs expected in it.
    typedef struct {
        logic        rst;
        logic        ifReq;
        logic [31:0] ifAddr;
        logic        dReq;
        logic        dWe;
        logic [31:0] dAddr;
        logic [63:0] dWdata;
        logic        ifGnt;
        logic        ifRv;
        logic        dGnt;
        logic        dRv;
        logic [31:0] rdAddr;
        logic        memRd;
        logic        memWe;
        logic [31:0] memAddr;
        logic [63:0] memWdata;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(
        input logic rst, input logic ifReq, input logic [31:0] ifAddr,
        input logic dReq, input logic dWe, input logic [31:0] dAddr, input logic [63:0] dWdata,
        input logic ifGnt, input logic ifRv, input logic dGnt, input logic dRv,
        input logic [31:0] rdAddr,
        input logic memRd, input logic memWe, input logic [31:0] memAddr, input logic [63:0] memWdata
    );
        vec_t v;
        v.rst = rst; v.ifReq = ifReq; v.ifAddr = ifAddr;
        v.dReq = dReq; v.dWe = dWe; v.dAddr = dAddr; v.dWdata = dWdata;
        v.ifGnt = ifGnt; v.ifRv = ifRv; v.dGnt = dGnt; v.dRv = dRv; v.rdAddr = rdAddr;
        v.memRd = memRd; v.memWe = memWe; v.memAddr = memAddr; v.memWdata = memWdata;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        reset       = v.rst;
        bus.if_req  = v.ifReq;
        bus.if_addr = v.ifAddr;
        bus.d_req   = v.dReq;
        bus.d_we    = v.dWe;
        bus.d_addr  = v.dAddr;
        bus.d_wdata = v.dWdata;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checksRun++;
        if (act === exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //      rst ifReq ifAddr  dReq dWe dAddr  dWdata | ifG ifRv dG dRv rdAddr memRd memWe memAddr memWdata
        // Outputs are held at 0 while reset is asserted, even with a request present.
        addVec(1, 1, 'h40,  0, 0, 'h0,   0,   0, 0, 0, 0, 'h0,   0, 0, 'h0,   0);
        // Single fetch read at T, return at T+2, then a new grant at T+3.
        addVec(0, 1, 'h40,  0, 0, 'h0,   0,   1, 0, 0, 0, 'h0,   1, 0, 'h40,  0);
        addVec(0, 0, 'h0,   0, 0, 'h0,   0,   0, 0, 0, 0, 'h0,   0, 0, 'h0,   0);
        addVec(0, 1, 'h48,  0, 0, 'h0,   0,   0, 1, 0, 0, 'h40,  0, 0, 'h0,   0);
        addVec(0, 1, 'h48,  0, 0, 'h0,   0,   1, 0, 0, 0, 'h0,   1, 0, 'h48,  0);
        addVec(0, 0, 'h0,   0, 0, 'h0,   0,   0, 0, 0, 0, 'h0,   0, 0, 'h0,   0);
        addVec(0, 0, 'h0,   0, 0, 'h0,   0,   0, 1, 0, 0, 'h48,  0, 0, 'h0,   0);
        // Re-reset, then both requests: IF at T, D load at T+3, d_rvalid at T+5.
        addVec(1, 0, 'h0,   0, 0, 'h0,   0,   0, 0, 0, 0, 'h0,   0, 0, 'h0,   0);
        addVec(0, 1, 'h0,   1, 0, 'h100, 0,   1, 0, 0, 0, 'h0,   1, 0, 'h0,   0);
        addVec(0, 0, 'h0,   1, 0, 'h100, 0,   0, 0, 0, 0, 'h0,   0, 0, 'h0,   0);
        addVec(0, 0, 'h0,   1, 0, 'h100, 0,   0, 1, 0, 0, 'h0,   0, 0, 'h0,   0);
        addVec(0, 0, 'h0,   1, 0, 'h100, 0,   0, 0, 1, 0, 'h0,   1, 0, 'h100, 0);
        addVec(0, 0, 'h0,   0, 0, 'h0,   0,   0, 0, 0, 0, 'h0,   0, 0, 'h0,   0);
        addVec(0, 0, 'h0,   0, 0, 'h0,   0,   0, 0, 0, 1, 'h100, 0, 0, 'h0,   0);
        // Three back-to-back stores.
        addVec(0, 0, 'h0,   1, 1, 'h200, 1,   0, 0, 1, 0, 'h0,   0, 1, 'h200, 1);
        addVec(0, 0, 'h0,   1, 1, 'h208, 2,   0, 0, 1, 0, 'h0,   0, 1, 'h208, 2);
        addVec(0, 0, 'h0,   1, 1, 'h210, 3,   0, 0, 1, 0, 'h0,   0, 1, 'h210, 3);
        addVec(0, 0, 'h0,   0, 0, 'h0,   0,   0, 0, 0, 0, 'h0,   0, 0, 'h0,   0);
        // IF kept busy while D alternates stores: the grants alternate.
        addVec(0, 1, 'h300, 1, 1, 'h400, 5,   1, 0, 0, 0, 'h0,   1, 0, 'h300, 0);
        addVec(0, 0, 'h0,   1, 1, 'h400, 5,   0, 0, 0, 0, 'h0,   0, 0, 'h0,   0);
        addVec(0, 1, 'h308, 1, 1, 'h400, 5,   0, 1, 0, 0, 'h300, 0, 0, 'h0,   0);
        addVec(0, 1, 'h308, 1, 1, 'h400, 5,   0, 0, 1, 0, 'h0,   0, 1, 'h400, 5);
        addVec(0, 1, 'h308, 1, 1, 'h408, 6,   1, 0, 0, 0, 'h0,   1, 0, 'h308, 0);
        addVec(0, 0, 'h0,   1, 1, 'h408, 6,   0, 0, 0, 0, 'h0,   0, 0, 'h0,   0);
        addVec(0, 1, 'h310, 1, 1, 'h408, 6,   0, 1, 0, 0, 'h308, 0, 0, 'h0,   0);
        addVec(0, 1, 'h310, 1, 1, 'h408, 6,   0, 0, 1, 0, 'h0,   0, 1, 'h408, 6);
        // Fetch read interrupted by reset at T+1: its rvalid is never produced.
        addVec(0, 1, 'h310, 0, 0, 'h0,   0,   1, 0, 0, 0, 'h0,   1, 0, 'h310, 0);
        addVec(1, 0, 'h0,   0, 0, 'h0,   0,   0, 0, 0, 0, 'h0,   0, 0, 'h0,   0);
        addVec(0, 0, 'h0,   0, 0, 'h0,   0,   0, 0, 0, 0, 'h0,   0, 0, 'h0,   0);
        // The first tie after reset goes to IF again.
        addVec(0, 1, 'h600, 1, 0, 'h700, 0,   1, 0, 0, 0, 'h0,   1, 0, 'h600, 0);
        addVec(0, 0, 'h0,   1, 0, 'h700, 0,   0, 0, 0, 0, 'h0,   0, 0, 'h0,   0);
        addVec(0, 0, 'h0,   1, 0, 'h700, 0,   0, 1, 0, 0, 'h600, 0, 0, 'h0,   0);
        addVec(0, 0, 'h0,   1, 0, 'h700, 0,   0, 0, 1, 0, 'h0,   1, 0, 'h700, 0);
        addVec(0, 0, 'h0,   0, 0, 'h0,   0,   0, 0, 0, 0, 'h0,   0, 0, 'h0,   0);
        addVec(0, 0, 'h0,   0, 0, 'h0,   0,   0, 0, 0, 1, 'h700, 0, 0, 'h0,   0);
        addVec(0, 0, 'h0,   0, 0, 'h0,   0,   0, 0, 0, 0, 'h0,   0, 0, 'h0,   0);

        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus1.if_req = 0; bus1.if_addr = '0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0;

        // Outputs of both instances while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset mem_rd",    64'(bus.mem_rd),   64'd0);
        checkOutput("reset if_gnt",    64'(bus.if_gnt),   64'd0);
        checkOutput("reset d_gnt",     64'(bus.d_gnt),    64'd0);
        checkOutput("reset mem_addr",  64'(bus.mem_addr), 64'd0);
        checkOutput("reset lat1 mem_rd", 64'(bus1.mem_rd), 64'd0);

        foreach (vecs[i]) begin
            vec_t v;
            logic [63:0] ifRdExp;
            logic [63:0] dRdExp;
            v = vecs[i];
            @(posedge clk);
            #1;
            applyStimulus(v);
            @(negedge clk);
            ifRdExp = v.ifRv ? memModel(v.rdAddr) : 64'd0;
            dRdExp  = v.dRv  ? memModel(v.rdAddr) : 64'd0;
            checkOutput($sformatf("row%0d if_gnt", i),    64'(bus.if_gnt),    64'(v.ifGnt));
            checkOutput($sformatf("row%0d if_rvalid", i), 64'(bus.if_rvalid), 64'(v.ifRv));
            checkOutput($sformatf("row%0d if_rdata", i),  bus.if_rdata,       ifRdExp);
            checkOutput($sformatf("row%0d d_gnt", i),     64'(bus.d_gnt),     64'(v.dGnt));
            checkOutput($sformatf("row%0d d_rvalid", i),  64'(bus.d_rvalid),  64'(v.dRv));
            checkOutput($sformatf("row%0d d_rdata", i),   bus.d_rdata,        dRdExp);
            checkOutput($sformatf("row%0d mem_rd", i),    64'(bus.mem_rd),    64'(v.memRd));
            checkOutput($sformatf("row%0d mem_we", i),    64'(bus.mem_we),    64'(v.memWe));
            checkOutput($sformatf("row%0d mem_addr", i),  64'(bus.mem_addr),  64'(v.memAddr));
            checkOutput($sformatf("row%0d mem_wdata", i), bus.mem_wdata,      v.memWdata);
        end

        // MEM_LAT=1 instance: read at T, rvalid at T+1, next grant at T+2.
        @(posedge clk); #1;
        reset = 0;
        bus1.if_req = 1; bus1.if_addr = 'h80;
        @(negedge clk);
        checkOutput("lat1 T if_gnt",   64'(bus1.if_gnt),   64'd1);
        checkOutput("lat1 T mem_rd",   64'(bus1.mem_rd),   64'd1);
        checkOutput("lat1 T mem_addr", 64'(bus1.mem_addr), 64'h80);

        @(posedge clk); #1;
        bus1.if_addr = 'h88;
        @(negedge clk);
        checkOutput("lat1 T+1 if_rvalid", 64'(bus1.if_rvalid), 64'd1);
        checkOutput("lat1 T+1 if_rdata",  bus1.if_rdata,       memModel(32'h80));
        checkOutput("lat1 T+1 if_gnt",    64'(bus1.if_gnt),    64'd0);
        checkOutput("lat1 T+1 mem_rd",    64'(bus1.mem_rd),    64'd0);

        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("lat1 T+2 if_gnt",    64'(bus1.if_gnt),    64'd1);
        checkOutput("lat1 T+2 mem_addr",  64'(bus1.mem_addr),  64'h88);
        checkOutput("lat1 T+2 if_rvalid", 64'(bus1.if_rvalid), 64'd0);

        @(posedge clk); #1;
        bus1.if_req = 0; bus1.if_addr = '0;
        @(negedge clk);
        checkOutput("lat1 T+3 if_rvalid", 64'(bus1.if_rvalid), 64'd1);
        checkOutput("lat1 T+3 if_rdata",  bus1.if_rdata,       memModel(32'h88));

        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("lat1 T+4 if_rvalid", 64'(bus1.if_rvalid), 64'd0);
        checkOutput("lat1 T+4 if_rdata",  bus1.if_rdata,       64'd0);

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
